// File: rtl/keccak_multirate_padder_pkg.sv
// Shared definitions for the multi-rate Keccak padder: rate selects, lane counts,
// padding constants and the controller state encoding.
package keccak_pad_pkg;

    localparam int LANE_W = 64;

    localparam logic [1:0] MODE_R1344 = 2'd0;
    localparam logic [1:0] MODE_R1088 = 2'd1;
    localparam logic [1:0] MODE_R832  = 2'd2;
    localparam logic [1:0] MODE_R576  = 2'd3;

    localparam logic [4:0] LANES_R1344 = 5'd21;
    localparam logic [4:0] LANES_R1088 = 5'd17;
    localparam logic [4:0] LANES_R832  = 5'd13;
    localparam logic [4:0] LANES_R576  = 5'd9;

    // Closing bit of pad10*1 sits in the last byte of the rate.
    localparam logic [7:0] PAD_END_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_PAD    = 2'd2,
        ST_FULL   = 2'd3
    } pad_state_t;

    function automatic logic [4:0] lanes_of(input logic [1:0] mode);
        logic [4:0] lanes;
        case (mode)
            MODE_R1344: lanes = LANES_R1344;
            MODE_R1088: lanes = LANES_R1088;
            MODE_R832:  lanes = LANES_R832;
            MODE_R576:  lanes = LANES_R576;
            default:    lanes = LANES_R576;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/keccak_multirate_padder_if.sv
// Message-side and permutation-side handshake bundle of the padder.
interface keccak_multirate_padder_if #(
    parameter int MAX_LANES = 21
);
    logic                     start;
    logic [1:0]               mode;
    logic [7:0]               dsep;
    logic [63:0]              in;
    logic                     in_valid;
    logic                     is_last;
    logic [2:0]               byte_num;
    logic                     in_ready;
    logic [64*MAX_LANES-1:0]  out;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;

    modport master (
        output start, mode, dsep, in, in_valid, is_last, byte_num, out_ready,
        input  in_ready, out, out_valid, out_last, busy
    );

    modport slave (
        input  start, mode, dsep, in, in_valid, is_last, byte_num, out_ready,
        output in_ready, out, out_valid, out_last, busy
    );
endinterface

// File: rtl/keccak_multirate_padder_word.sv
// Builds the lane shifted in for an accepted word: masks unused bytes of a final
// word, inserts the domain byte and closes the rate when it is the last lane.
module keccak_pad_word
    import keccak_pad_pkg::*;
(
    input  logic [63:0] in_i,
    input  logic [2:0]  byte_num_i,
    input  logic [7:0]  dsep_i,
    input  logic        is_last_i,
    input  logic        final_lane_i,
    output logic [63:0] v_o
);
    logic [63:0] masked_s;

    // Byte 0 is the most significant byte; bytes past byte_num are dropped.
    always_comb begin
        masked_s = in_i;
        if (is_last_i) begin
            for (int k = 0; k < 8; k++) begin
                if (3'(k) < byte_num_i) begin
                    masked_s[63-8*k -: 8] = in_i[63-8*k -: 8];
                end else if (3'(k) == byte_num_i) begin
                    masked_s[63-8*k -: 8] = dsep_i;
                end else begin
                    masked_s[63-8*k -: 8] = 8'h00;
                end
            end
        end else begin
            masked_s = in_i;
        end
    end

    // Final padding bit only when the message ends inside the rate's last lane.
    always_comb begin
        v_o = masked_s;
        if (is_last_i && final_lane_i) begin
            v_o = {masked_s[63:8], masked_s[7:0] | PAD_END_BYTE};
        end else begin
            v_o = masked_s;
        end
    end

endmodule

// File: rtl/keccak_multirate_padder.sv
// Multi-rate SHA-3/SHAKE message padder: packs 64-bit words into rate-sized
// blocks, applies pad10*1 with a runtime domain byte and hands blocks downstream.
module keccak_multirate_padder
    import keccak_pad_pkg::*;
#(
    parameter int MAX_LANES = 21,
    parameter int CNT_W     = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    keccak_multirate_padder_if.slave      bus
);
    localparam int OUT_W = LANE_W * MAX_LANES;

    pad_state_t         state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   lanes_q, lanes_d;
    logic [7:0]         dsep_q, dsep_d;
    logic               last_q, last_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;

    logic               accept_s;
    logic               final_lane_s;
    logic               block_done_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [63:0]        word_s;
    logic [63:0]        pad_lane_s;

    assign accept_s     = bus.in_valid & in_ready_q & (state_q == ST_ABSORB);
    assign cnt_inc_s    = cnt_q + CNT_W'(1);
    assign final_lane_s = (cnt_q == (lanes_q - CNT_W'(1)));
    assign block_done_s = (cnt_inc_s == lanes_q);
    assign pad_lane_s   = final_lane_s ? {56'd0, PAD_END_BYTE} : 64'd0;

    keccak_pad_word u_word (
        .in_i         (bus.in),
        .byte_num_i   (bus.byte_num),
        .dsep_i       (dsep_q),
        .is_last_i    (bus.is_last),
        .final_lane_i (final_lane_s),
        .v_o          (word_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            cnt_q       <= '0;
            lanes_q     <= '0;
            dsep_q      <= 8'h00;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            lanes_q     <= lanes_d;
            dsep_q      <= dsep_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and block assembly; new lanes enter at the bottom.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        dsep_d  = dsep_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    lanes_d = CNT_W'(lanes_of(bus.mode));
                    dsep_d  = bus.dsep;
                    last_d  = 1'b0;
                    state_d = ST_ABSORB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABSORB: begin
                if (accept_s) begin
                    out_d = {out_q[OUT_W-65:0], word_s};
                    cnt_d = cnt_inc_s;
                    if (block_done_s) begin
                        last_d  = bus.is_last;
                        state_d = ST_FULL;
                    end else if (bus.is_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end else begin
                    state_d = ST_ABSORB;
                end
            end
            ST_PAD: begin
                out_d = {out_q[OUT_W-65:0], pad_lane_s};
                cnt_d = cnt_inc_s;
                if (block_done_s) begin
                    last_d  = 1'b1;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    out_d   = '0;
                    cnt_d   = '0;
                    state_d = last_q ? ST_IDLE : ST_ABSORB;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        in_ready_d  = (state_d == ST_ABSORB);
        out_valid_d = (state_d == ST_FULL);
        out_last_d  = (state_d == ST_FULL) & last_d;
        busy_d      = (state_d != ST_IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_keccak_multirate_padder.sv
// Bench for keccak_multirate_padder: a byte-stream pad10*1 reference model feeds a
// block scoreboard; table vectors plus backpressure and reset-abort sequences.
module tb_keccak_multirate_padder;
    localparam int ML = 21;
    localparam int OW = 64 * ML;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } blk_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  dsep;
        int          nfull;
        logic [63:0] fill;
        logic [63:0] last_in;
        logic [2:0]  bn;
        int          lat;
        int          chk_lane;
        logic [63:0] chk_val;
        logic [63:0] chk0;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keccak_multirate_padder_if #(.MAX_LANES(ML)) bus ();

    keccak_multirate_padder #(.MAX_LANES(ML), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    blk_t          exp_q[$];
    logic [OW-1:0] last_blk;
    logic [7:0]    pb [0:1023];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int lanes_for(input logic [1:0] m);
        case (m)
            2'd0:    return 21;
            2'd1:    return 17;
            2'd2:    return 13;
            default: return 9;
        endcase
    endfunction

    // Reference: message as a byte stream, dsep appended, 0x80 on the rate's last byte.
    task automatic model_push(input vec_t v);
        int L, R, len, P;
        logic [63:0] w;
        logic [63:0] lane;
        blk_t e;
        L   = lanes_for(v.mode);
        R   = 8 * L;
        len = 8 * v.nfull + int'(v.bn);
        P   = ((len + R) / R) * R;
        for (int i = 0; i < P; i++) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) begin
            w = (i / 8 < v.nfull) ? v.fill : v.last_in;
            pb[i] = w[63 - 8*(i % 8) -: 8];
        end
        pb[len]   = v.dsep;
        pb[P - 1] = pb[P - 1] | 8'h80;
        for (int b = 0; b < P / R; b++) begin
            e.data = '0;
            for (int j = 0; j < L; j++) begin
                lane = 64'd0;
                for (int k = 0; k < 8; k++) lane = {lane[55:0], pb[b*R + 8*j + k]};
                e.data[64*(L-1-j) +: 64] = lane;
            end
            e.last = (b == P / R - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic mon();
        blk_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_block: got last=%0b expected no block", bus.out_last);
            end else begin
                e = exp_q.pop_front();
                if (bus.out !== e.data || bus.out_last !== e.last) begin
                    n_err++;
                    for (int j = ML - 1; j >= 0; j--) begin
                        if (bus.out[64*j +: 64] !== e.data[64*j +: 64]) begin
                            $display("FAIL block lane%0d: got %h expected %h", j,
                                     bus.out[64*j +: 64], e.data[64*j +: 64]);
                            break;
                        end
                    end
                    $display("FAIL block_last: got %0b expected %0b", bus.out_last, e.last);
                end
                last_blk = bus.out;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [1:0] m, input logic [7:0] d);
        bus.mode  = m;
        bus.dsep  = d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic put_word(input logic [63:0] d, input logic l, input logic [2:0] bn);
        int   n;
        logic r;
        n = 0;
        bus.in       = d;
        bus.is_last  = l;
        bus.byte_num = bn;
        bus.in_valid = 1'b1;
        do begin
            r = bus.in_ready;
            tick();
            n++;
        end while (!r && n < 200);
        bus.in_valid = 1'b0;
        bus.is_last  = 1'b0;
        if (!r) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        model_push(v);
        start_msg(v.mode, v.dsep);
        for (int i = 0; i < v.nfull; i++) put_word(v.fill, 1'b0, 3'd0);
        put_word(v.last_in, 1'b1, v.bn);
        n = 0;
        while (!bus.out_valid && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(v.lat));
        wait_idle();
        chk({tag, "_lane_sel"}, last_blk[64*v.chk_lane +: 64], v.chk_val);
        chk({tag, "_lane0"}, last_blk[63:0], v.chk0);
        chk({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        vec_t        vt [6];
        vec_t        bp;
        logic [OW-1:0] snap;
        int          n;

        vt[0] = '{mode: 2'd1, dsep: 8'h06, nfull: 0, fill: 64'h0, last_in: 64'h0, bn: 3'd0,
                  lat: 16, chk_lane: 16, chk_val: 64'h0600000000000000, chk0: 64'h0000000000000080};
        vt[1] = '{mode: 2'd3, dsep: 8'h06, nfull: 9, fill: 64'h1111111111111111, last_in: 64'h0, bn: 3'd0,
                  lat: 8, chk_lane: 8, chk_val: 64'h0600000000000000, chk0: 64'h0000000000000080};
        vt[2] = '{mode: 2'd0, dsep: 8'h1F, nfull: 20, fill: 64'h0123456789ABCDEF, last_in: 64'h0102030405060700,
                  bn: 3'd7, lat: 0, chk_lane: 20, chk_val: 64'h0123456789ABCDEF, chk0: 64'h010203040506079F};
        vt[3] = '{mode: 2'd2, dsep: 8'h1F, nfull: 0, fill: 64'h0, last_in: 64'hAABBCC0000000000, bn: 3'd3,
                  lat: 12, chk_lane: 12, chk_val: 64'hAABBCC1F00000000, chk0: 64'h0000000000000080};
        vt[4] = '{mode: 2'd3, dsep: 8'h01, nfull: 3, fill: 64'h5A5A5A5A5A5A5A5A, last_in: 64'hDEADBEEFCAFEF00D,
                  bn: 3'd5, lat: 5, chk_lane: 5, chk_val: 64'hDEADBEEFCA010000, chk0: 64'h0000000000000080};
        vt[5] = '{mode: 2'd3, dsep: 8'h06, nfull: 8, fill: 64'h0F1E2D3C4B5A6978, last_in: 64'h0, bn: 3'd0,
                  lat: 0, chk_lane: 1, chk_val: 64'h0F1E2D3C4B5A6978, chk0: 64'h0600000000000080};

        bus.start = 1'b0; bus.mode = 2'd0; bus.dsep = 8'h00; bus.in = 64'd0;
        bus.in_valid = 1'b0; bus.is_last = 1'b0; bus.byte_num = 3'd0; bus.out_ready = 1'b1;
        last_blk = '0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_zero", 64'(|bus.out), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Held block under backpressure; stray start and words must be ignored.
        bp = '{mode: 2'd3, dsep: 8'h06, nfull: 9, fill: 64'hA5A5A5A5C3C3C3C3, last_in: 64'h0, bn: 3'd0,
               lat: 0, chk_lane: 8, chk_val: 64'h0600000000000000, chk0: 64'h0000000000000080};
        model_push(bp);
        bus.out_ready = 1'b0;
        start_msg(bp.mode, bp.dsep);
        for (int i = 0; i < 9; i++) put_word(bp.fill, 1'b0, 3'd0);
        n = 0;
        while (!bus.out_valid && n < 64) begin
            tick();
            n++;
        end
        chk("bp_full_latency", 64'(n), 64'd0);
        chk("bp_out_last", 64'(bus.out_last), 64'd0);
        snap = bus.out;
        for (int c = 0; c < 5; c++) begin
            bus.in       = {$urandom(), $urandom()};
            bus.in_valid = 1'b1;
            bus.start    = 1'b1;
            bus.mode     = 2'd0;
            tick();
            chk("bp_out_stable", 64'(bus.out === snap), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_resume_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_resume_out_valid", 64'(bus.out_valid), 64'd0);
        put_word(bp.last_in, 1'b1, bp.bn);
        wait_idle();
        chk("bp_lane8", last_blk[64*8 +: 64], bp.chk_val);
        chk("bp_lane0", last_blk[63:0], bp.chk0);

        // Abort after five words: nothing of that message may appear.
        start_msg(2'd0, 8'h1F);
        for (int i = 0; i < 5; i++) put_word(64'hFEEDFACE00000000 + 64'(i), 1'b0, 3'd0);
        reset = 1'b1;
        tick();
        chk("abort_out_zero", 64'(|bus.out), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        tick();
        run_vec(vt[3], "after_abort");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keccak_multirate_padder.md
Name: keccak_multirate_padder

Overview:
- Runtime-configurable Keccak/SHA-3 message padder.
- Accepts 64-bit message words from the user side and packs them into rate-sized blocks for the f-permutation.
- Applies pad10*1 with a runtime domain-separation byte.
- Unlike the single-rate, single-message padder, it supports four rates chosen per message, valid/ready on both sides, a final-block flag, and back-to-back messages without reset.

Parameters:
- MAX_LANES, 21, lanes in the widest rate (SHAKE128, 1344 bits). Output width is 64*MAX_LANES.
- CNT_W, 5, width of the lane counter. Must satisfy 2^CNT_W > MAX_LANES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin new message; honoured only in IDLE
- mode  in  2  rate select, sampled on start: 0=1344 bits (21 lanes), 1=1088 (17), 2=832 (13), 3=576 (9)
- dsep  in  8  domain byte, sampled on start (0x06 SHA-3, 0x1F SHAKE, 0x01 Keccak)
- in  in  64  message word; byte 0 is in[63:56], byte 7 is in[7:0]
- in_valid  in  1  word valid
- is_last  in  1  word is final; only bytes 0..byte_num-1 are valid
- byte_num  in  3  valid bytes in the last word (0..7); ignored when is_last=0 (word counts as 8 bytes)
- in_ready  out  1  word accepted when in_valid & in_ready
- out  out  64*MAX_LANES  block; lanes at and above L are zero
- out_valid  out  1  block complete
- out_last  out  1  block is the final block of the message; valid with out_valid
- out_ready  in  1  permutation consumes block on out_valid & out_ready
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; out, cnt, flags cleared; in_ready=0, out_valid=0, out_last=0, busy=0.
- Reset mid-operation aborts the message; no partial block is emitted.
- Lane count L is decoded from the latched mode via the package table and is constant for the whole message.
- FSM:
  - IDLE: on start, latch mode, dsep; go ABSORB. in_ready=0.
  - ABSORB: in_ready=1. Each accepted word shifts in: out <= {out shifted up 64, v}, cnt++.
    - Word with is_last=0: v=in. If cnt reaches L, go FULL with last_flag=0.
    - Word with is_last=1: v = in with bytes >= byte_num zeroed, dsep placed at byte byte_num, and 0x80 ORed into bits[7:0] if this is lane L-1 of the block. Then go FULL (last_flag=1) if cnt reaches L, else go PAD.
  - PAD: in_ready=0. Shift one lane per cycle: zero, plus 0x80 in bits[7:0] when filling lane L-1. Go FULL with last_flag=1 when cnt reaches L.
  - FULL: out_valid=1, out_last=last_flag; out held stable.
    - On out_ready: clear out and cnt.
    - If last_flag=1, go IDLE; else go ABSORB.
    - in_ready stays 0 in FULL, so there is one bubble cycle after each drain.
- Block layout: first word of a block lands in out[64*L-1 -: 64]; last lane in out[63:0].
- Whole-block messages: a message whose byte length is a multiple of 8 ends with an is_last word with byte_num=0. That word may start a fresh block.
- start outside IDLE is ignored. in_valid outside ABSORB is ignored and never accepted.
- in_valid=0 in ABSORB: no shift, no state change, so the user may stall indefinitely.
- out_ready held low: out, out_valid and out_last hold indefinitely.
- Latency: the last data word is visible on out_valid at the earliest one cycle later when the block fills; otherwise after (L-cnt) PAD cycles.

Decomposition:
- keccak_pad_pkg holds:
  - mode encodings;
  - lane-count lookup function (mode to L);
  - rate constants;
  - FSM state enum.
- Sub-module keccak_pad_word (combinational): in, byte_num, dsep, is_last, final_lane → v. It does byte masking, dsep insertion and the 0x80 OR.

Test Plan:
- SHA3-256 empty message: start mode=1 dsep=0x06; one word is_last=1 byte_num=0 → after 16 PAD cycles out_valid=1, out_last=1; lane16=0x0600000000000000; lane0=0x0000000000000080; lanes 1-15 and 17-20 zero.
- SHA3-512 (mode=3, dsep=0x06), 9 full words 0x1111...11 then is_last byte_num=0:
  - block 1: out_last=0, lanes 8..0 all 0x1111111111111111;
  - block 2: out_last=1, lane8=0x0600000000000000, lane0=0x80.
- SHAKE128 (mode=0, dsep=0x1F), 20 full words then is_last byte_num=7 in=0x0102030405060700 → single block with out_last=1; lane0=0x010203040506079F; no PAD cycles.
- Backpressure: out_ready=0 for 5 cycles while FULL → out stable, in_ready=0, in_valid pulses not accepted. One cycle after out_ready=1, state returns to ABSORB.
- Back-to-back messages: after the final drain, state returns to IDLE and busy=0. start mode=2 dsep=0x1F with one word is_last byte_num=3 in=0xAABBCC0000000000 → lane12=0xAABBCC1F00000000, lane0=0x80.
- Reset mid-absorb: assert reset after 5 words → next cycle out=0, out_valid=0, busy=0, in_ready=0. A new message then completes correctly.
